bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It adds configurable input width and digit count, an optional two's-complement signed mode, and a sticky overflow flag. It uses a start/busy/done handshake and registered outputs that hold until the next conversion. It sits between the measurement/arithmetic datapath and the seven-segment display driver.

## Interface
- BIN_W, 12: binary input width in bits; legal range 2..32.
- DIGITS, 4: number of BCD output digits; legal range 1..10.
- SIGNED, 0: 0 = `bin_in` is unsigned; 1 = `bin_in` is two's complement.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  BIN_W  binary operand; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; `bcd_out`, `sign_out` and `overflow` are valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD result; digit 0 is in bits [3:0].
- sign_out  out  1  1 = result is negative (SIGNED=1 only; otherwise tied 0).
- overflow  out  1  1 = magnitude ≥ 10^DIGITS; `bcd_out` then holds the magnitude mod 10^DIGITS.

## Operation
- Two states: IDLE and CONV.
- IDLE:
  - On `start`=1, capture the magnitude of `bin_in` into the BIN_W-bit binary shift field.
  - Clear the 4*DIGITS-bit BCD field, the bit counter and the internal overflow accumulator.
  - Latch the sign internally, set `busy`, go to CONV.
- Signed capture (SIGNED=1): if `bin_in`[BIN_W-1]=1, magnitude = (~bin_in + 1) as unsigned BIN_W, and sign = 1.
  - -2^(BIN_W-1) therefore converts to +2^(BIN_W-1).
  - Zero is never negative.
- CONV, one iteration per cycle, with the whole step done in one cycle:
  - In every digit in parallel, add 3 to any digit ≥ 5.
  - Then shift the {BCD, binary} concatenation left by one.
  - OR the bit shifted out of the top BCD digit into the overflow accumulator.
  - Increment the counter.
- On the iteration where the counter equals BIN_W-1 (the last shift):
  - Write the post-shift BCD field to `bcd_out`, the accumulated overflow (including this shift's carry-out) to `overflow`, and the latched sign to `sign_out`.
  - Pulse `done`, clear `busy`, return to IDLE.
- Outputs hold their last result until the next `done`; they are not cleared by a new start.
- `start` while `busy`=1 is ignored and not queued.
- `bin_in` changes after the capture edge have no effect.
- Counter width: $clog2(BIN_W)+1 bits. The BCD adders are 4-bit; a digit never exceeds 9 after adjust-then-shift, except for the top digit's discarded carry.

## Timing
- Reset (`rst_n`=0 at a rising edge): state = IDLE; `busy`, `done`, `bcd_out`, `sign_out`, `overflow` = 0.
- Reset mid-conversion aborts the conversion; no `done` is produced.
- Reset has priority over `start` on the same edge.
- Latency: `start` accepted at edge E → `busy`=1 after E → `done`=1 and results valid after edge E+BIN_W. `busy` is high for exactly BIN_W cycles.
- `done` is high for exactly one cycle; `busy` and `done` are never high together.
- Back-to-back operation: `start` held high, or asserted in the `done` cycle, is accepted at edge E+BIN_W+1. Throughput is one result per BIN_W+1 cycles.
- No combinational path from any input to any output.

## Test plan
- BIN_W=12, DIGITS=4, unsigned; `bin_in`=4095 → `done` exactly 12 cycles after the start edge; `bcd_out`=16'h4095; `overflow`=0; `busy` high for 12 cycles.
- BIN_W=16, DIGITS=5; sweep `bin_in` = 0, 9, 10, 99, 100, 65535 → `bcd_out` = 20'h00000, 20'h00009, 20'h00010, 20'h00099, 20'h00100, 20'h65535; each `done` 16 cycles after its start.
- BIN_W=12, DIGITS=4, SIGNED=1:
  - `bin_in`=12'h800 → `sign_out`=1, `bcd_out`=16'h2048.
  - `bin_in`=12'hFFF → `sign_out`=1, `bcd_out`=16'h0001.
  - `bin_in`=0 → `sign_out`=0, `bcd_out`=0.
- BIN_W=12, DIGITS=3:
  - `bin_in`=1000 → `overflow`=1, `bcd_out`=12'h000.
  - `bin_in`=999 → `overflow`=0, `bcd_out`=12'h999.
  - `bin_in`=4095 → `overflow`=1, `bcd_out`=12'h095.
- Handshake:
  - Start 123, then pulse `start` with 456 at cycle 5 of the conversion → only 123 is produced; the second start is ignored.
  - Hold `start` high with `bin_in`=7 → results every 13 cycles; `done` one cycle wide each time.
- Reset: assert `rst_n`=0 at cycle 6 of a conversion for one cycle → all outputs 0, no `done`; a following start of 42 yields 16'h0042 12 cycles later.

Source files
------------

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/busy/done handshake and result bus for bin2bcd_seq.
//   start    : request a conversion (master -> slave)
//   bin_in   : BIN_W-bit binary operand (master -> slave)
//   busy     : conversion in progress (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   bcd_out  : 4*DIGITS-bit packed BCD, digit 0 in [3:0] (slave -> master)
//   sign_out : result is negative (slave -> master)
//   overflow : magnitude did not fit in DIGITS digits (slave -> master)
interface bin2bcd_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, sign_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, sign_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// One bit is consumed per cycle, so a conversion takes BIN_W cycles after
// the accepting start edge. Results are registered and held until the next
// done pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bin2bcd_if slave (start, bin_in in; busy, done, bcd_out,
//           sign_out, overflow out)
// Parameters: BIN_W (2..32), DIGITS (1..10), SIGNED (0 unsigned, 1 two's
// complement input).
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W) + 1;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
  logic              sign_out_q, sign_out_d;
  logic              ovf_out_q, ovf_out_d;

  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              sign_q, sign_d;

  logic              neg;
  logic [BIN_W-1:0]  mag;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  bcd_sh;
  logic [BIN_W-1:0]  bin_sh;
  logic              carry;

  // Negative operands are converted as their magnitude; the most negative
  // value wraps to +2^(BIN_W-1), which still fits unsigned in BIN_W bits.
  assign neg = (SIGNED != 0) && bus.bin_in[BIN_W-1];
  assign mag = neg ? (~bus.bin_in + 1'b1) : bus.bin_in;

  // Adjust, then shift {BCD, binary} left by one; the bit leaving the top
  // digit is the overflow carry.
  assign adj = dd_adjust(bcd_q);
  assign {carry, bcd_sh, bin_sh} = {adj, bin_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_out_d  = bcd_out_q;
    sign_out_d = sign_out_q;
    ovf_out_d  = ovf_out_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    sign_d     = sign_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = mag;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          sign_d  = neg;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) begin
          bcd_out_d  = bcd_sh;
          ovf_out_d  = ovf_q | carry;
          sign_out_d = sign_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and visible outputs: reset to a known idle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      sign_out_q <= 1'b0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_out_q  <= bcd_out_d;
      sign_out_q <= sign_out_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  // Working datapath: always initialised on an accepted start, so no reset.
  always_ff @(posedge clk) begin
    bin_q  <= bin_d;
    bcd_q  <= bcd_d;
    ovf_q  <= ovf_d;
    sign_q <= sign_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_out_q;
  assign bus.sign_out = sign_out_q;
  assign bus.overflow = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: four configurations side by side
//   0: BIN_W=12 DIGITS=4 unsigned   1: BIN_W=16 DIGITS=5 unsigned
//   2: BIN_W=12 DIGITS=4 signed     3: BIN_W=12 DIGITS=3 unsigned
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] prev_bcd [4];

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(12), .DIGITS(4)) ifa ();
  bin2bcd_if #(.BIN_W(16), .DIGITS(5)) ifb ();
  bin2bcd_if #(.BIN_W(12), .DIGITS(4)) ifc ();
  bin2bcd_if #(.BIN_W(12), .DIGITS(3)) ifd ();

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  function automatic int bw(input int k);
    return (k == 1) ? 16 : 12;
  endfunction
  function automatic int dg(input int k);
    return (k == 1) ? 5 : ((k == 3) ? 3 : 4);
  endfunction
  function automatic bit sg(input int k);
    return (k == 2);
  endfunction

  task automatic set_in(input int k, input logic st, input logic [31:0] v);
    case (k)
      0: begin ifa.start = st; ifa.bin_in = v[11:0]; end
      1: begin ifb.start = st; ifb.bin_in = v[15:0]; end
      2: begin ifc.start = st; ifc.bin_in = v[11:0]; end
      default: begin ifd.start = st; ifd.bin_in = v[11:0]; end
    endcase
  endtask

  function automatic logic get_done(input int k);
    case (k)
      0: return ifa.done;
      1: return ifb.done;
      2: return ifc.done;
      default: return ifd.done;
    endcase
  endfunction
  function automatic logic get_busy(input int k);
    case (k)
      0: return ifa.busy;
      1: return ifb.busy;
      2: return ifc.busy;
      default: return ifd.busy;
    endcase
  endfunction
  function automatic logic [39:0] get_bcd(input int k);
    case (k)
      0: return 40'(ifa.bcd_out);
      1: return 40'(ifb.bcd_out);
      2: return 40'(ifc.bcd_out);
      default: return 40'(ifd.bcd_out);
    endcase
  endfunction
  function automatic logic get_sign(input int k);
    case (k)
      0: return ifa.sign_out;
      1: return ifb.sign_out;
      2: return ifc.sign_out;
      default: return ifd.sign_out;
    endcase
  endfunction
  function automatic logic get_ovf(input int k);
    case (k)
      0: return ifa.overflow;
      1: return ifb.overflow;
      2: return ifc.overflow;
      default: return ifd.overflow;
    endcase
  endfunction

  // Reference: decimal digits of the magnitude by plain division.
  task automatic model(input int k, input logic [31:0] v, output logic [39:0] bcd,
                       output logic s, output logic o);
    longint mag, lim, r;
    int w;
    w   = bw(k);
    mag = longint'(v) & ((64'sd1 << w) - 1);
    s   = 1'b0;
    if (sg(k) && v[w-1]) begin
      mag = (64'sd1 << w) - mag;
      s   = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < dg(k); i++) lim = lim * 10;
    o   = (mag >= lim);
    r   = mag % lim;
    bcd = '0;
    for (int i = 0; i < dg(k); i++) begin
      bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One conversion on instance k; optionally pulse start with v2 at cycle intr.
  task automatic run(input int k, input logic [31:0] v, input int intr,
                     input logic [31:0] v2, input string tag);
    logic [39:0] eb;
    logic es, eo;
    int n, bc;
    model(k, v, eb, es, eo);
    @(negedge clk);
    set_in(k, 1'b1, v);
    @(posedge clk); #1;
    set_in(k, 1'b0, $urandom);
    chk({tag, "_busy0"}, 40'(get_busy(k)), 40'd1);
    chk({tag, "_hold"}, get_bcd(k), prev_bcd[k]);
    n = 0;
    bc = 0;
    while (!get_done(k) && n < 100) begin
      if (get_busy(k)) bc++;
      @(posedge clk); #1;
      n++;
      if (n == intr) set_in(k, 1'b1, v2);
      else if (n == intr + 1) set_in(k, 1'b0, v2);
    end
    chk({tag, "_lat"}, 40'(n), 40'(bw(k)));
    chk({tag, "_busycyc"}, 40'(bc), 40'(bw(k)));
    chk({tag, "_busydone"}, 40'(get_busy(k)), 40'd0);
    chk({tag, "_bcd"}, get_bcd(k), eb);
    chk({tag, "_sign"}, 40'(get_sign(k)), 40'(es));
    chk({tag, "_ovf"}, 40'(get_ovf(k)), 40'(eo));
    @(posedge clk); #1;
    chk({tag, "_done1"}, 40'(get_done(k)), 40'd0);
    chk({tag, "_idle"}, 40'(get_busy(k)), 40'd0);
    chk({tag, "_keep"}, get_bcd(k), eb);
    prev_bcd[k] = eb;
  endtask

  initial begin
    int n, cnt;
    int dq[$];
    logic [31:0] rv;
    for (int k = 0; k < 4; k++) begin
      set_in(k, 1'b0, 32'd0);
      prev_bcd[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst%0d_busy", k), 40'(get_busy(k)), 40'd0);
      chk($sformatf("rst%0d_done", k), 40'(get_done(k)), 40'd0);
      chk($sformatf("rst%0d_bcd", k), get_bcd(k), 40'd0);
      chk($sformatf("rst%0d_sign", k), 40'(get_sign(k)), 40'd0);
      chk($sformatf("rst%0d_ovf", k), 40'(get_ovf(k)), 40'd0);
    end
    rst_n = 1'b1;

    // Directed values
    run(0, 4095, -1, 0, "a4095");
    chk("a4095_lit", get_bcd(0), 40'h4095);
    run(1, 0, -1, 0, "b0");
    run(1, 9, -1, 0, "b9");
    run(1, 10, -1, 0, "b10");
    run(1, 99, -1, 0, "b99");
    run(1, 100, -1, 0, "b100");
    run(1, 65535, -1, 0, "b65535");
    chk("b65535_lit", get_bcd(1), 40'h65535);
    run(2, 32'h800, -1, 0, "c800");
    chk("c800_lit", get_bcd(2), 40'h2048);
    run(2, 32'hFFF, -1, 0, "cfff");
    run(2, 0, -1, 0, "c0");
    run(3, 1000, -1, 0, "d1000");
    run(3, 999, -1, 0, "d999");
    run(3, 4095, -1, 0, "d4095");
    chk("d4095_lit", get_bcd(3), 40'h095);

    // Random operands on every configuration
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        rv = $urandom;
        run(k, rv, -1, 0, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    // Start during busy is ignored
    run(0, 123, 5, 456, "busy_ign");
    chk("busy_ign_lit", get_bcd(0), 40'h0123);

    // Start held high: one result every BIN_W+1 cycles
    @(negedge clk);
    set_in(0, 1'b1, 7);
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.done) begin
        dq.push_back(n);
        chk($sformatf("hold_bcd%0d", n), get_bcd(0), 40'h0007);
      end
      @(posedge clk); #1;
      n++;
    end
    set_in(0, 1'b0, 0);
    chk("hold_cnt", 40'(dq.size()), 40'd3);
    if (dq.size() == 3) begin
      chk("hold_t0", 40'(dq[0]), 40'd12);
      chk("hold_t1", 40'(dq[1]), 40'd25);
      chk("hold_t2", 40'(dq[2]), 40'd38);
    end
    cnt = 0;
    while (ifa.busy && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("hold_drain", 40'(ifa.busy), 40'd0);
    @(posedge clk); #1;
    prev_bcd[0] = 40'h0007;

    // Reset at cycle 6 of a conversion
    @(negedge clk);
    set_in(0, 1'b1, 99);
    @(posedge clk); #1;
    set_in(0, 1'b0, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid%0d_busy", k), 40'(get_busy(k)), 40'd0);
      chk($sformatf("mid%0d_done", k), 40'(get_done(k)), 40'd0);
      chk($sformatf("mid%0d_bcd", k), get_bcd(k), 40'd0);
      chk($sformatf("mid%0d_sign", k), 40'(get_sign(k)), 40'd0);
      chk($sformatf("mid%0d_ovf", k), 40'(get_ovf(k)), 40'd0);
      prev_bcd[k] = '0;
    end
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ifa.done || ifa.busy) cnt++;
    end
    chk("mid_nodone", 40'(cnt), 40'd0);
    run(0, 42, -1, 0, "post42");
    chk("post42_lit", get_bcd(0), 40'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
